cdb_arbiter: RTL and testbench

- Common data bus (CDB) arbiter and broadcaster. It is the consuming end of the execution units' result ready-valid channels (rs_id, result_reg_addr, result, cr0_xer).
- Each cycle it selects at most one pending unit result, round-robin, and registers it onto the CDB.
- The CDB drives all reservation stations' operand/XER update ports and the commit/register-file path.
- Downstream backpressure arrives via cdb_ready.

---
 rtl/cdb_arbiter.sv | 92 +++++++++
 tb/tb_cdb_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with a registered broadcast slot
package cdb_arbiter_pkg;
  typedef struct packed {
    logic [0:3] cr0;
    logic       so;
    logic       ov;
    logic       ca;
  } cond_exception_t;
endpackage

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int UNITS       = 4,
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic            [0:UNITS-1]           unit_valid,
  output logic            [0:UNITS-1]           unit_ready,
  input  logic            [0:UNITS-1][0:RS_ID_WIDTH-1] unit_rs_id,
  input  logic            [0:UNITS-1][0:4]      unit_result_reg_addr,
  input  logic            [0:UNITS-1][0:31]     unit_result,
  input  cond_exception_t [0:UNITS-1]           unit_cr0_xer,
  output logic                                  cdb_valid,
  input  logic                                  cdb_ready,
  output logic            [0:RS_ID_WIDTH-1]     cdb_rs_id,
  output logic            [0:4]                 cdb_result_reg_addr,
  output logic            [0:31]                cdb_result,
  output cond_exception_t                       cdb_cr0_xer,
  output logic            [0:$clog2(UNITS)-1]   cdb_grant_idx
);

  localparam int IDX_W = $clog2(UNITS);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W:0]   cand;
  logic             grant_any;
  logic             slot_free;

  // The slot can accept a new result when empty or when it drains this cycle.
  assign slot_free = !cdb_valid || cdb_ready;

  always_comb begin
    unit_ready = '0;
    grant_idx  = '0;
    grant_any  = 1'b0;
    cand       = '0;
    if (!rst && slot_free) begin
      for (int i = 0; i < UNITS; i++) begin
        cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
        if (cand >= (IDX_W+1)'(UNITS)) cand = cand - (IDX_W+1)'(UNITS);
        if (!grant_any && unit_valid[cand[IDX_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand[IDX_W-1:0];
        end
      end
      if (grant_any) unit_ready[grant_idx] = 1'b1;
    end
  end

  // Explicit wrap so non-power-of-two unit counts never point past the last unit.
  always_comb begin
    next_ptr = grant_idx + 1'b1;
    if (grant_idx == IDX_W'(UNITS - 1)) next_ptr = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid           <= 1'b0;
      cdb_rs_id           <= '0;
      cdb_result_reg_addr <= '0;
      cdb_result          <= '0;
      cdb_cr0_xer         <= '0;
      cdb_grant_idx       <= '0;
      rr_ptr              <= '0;
    end else if (grant_any) begin
      cdb_valid           <= 1'b1;
      cdb_rs_id           <= unit_rs_id[grant_idx];
      cdb_result_reg_addr <= unit_result_reg_addr[grant_idx];
      cdb_result          <= unit_result[grant_idx];
      cdb_cr0_xer         <= unit_cr0_xer[grant_idx];
      cdb_grant_idx       <= grant_idx;
      rr_ptr              <= next_ptr;
    end else if (cdb_ready) begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - table-driven and randomized model checks for cdb_arbiter
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int UNITS = 4;
  localparam int RSW   = 5;

  logic                          clk;
  logic                          rst;
  logic            [0:UNITS-1]   unit_valid;
  logic            [0:UNITS-1]   unit_ready;
  logic            [0:UNITS-1][0:RSW-1] unit_rs_id;
  logic            [0:UNITS-1][0:4]  unit_result_reg_addr;
  logic            [0:UNITS-1][0:31] unit_result;
  cond_exception_t [0:UNITS-1]   unit_cr0_xer;
  logic                          cdb_valid;
  logic                          cdb_ready;
  logic            [0:RSW-1]     cdb_rs_id;
  logic            [0:4]         cdb_result_reg_addr;
  logic            [0:31]        cdb_result;
  cond_exception_t               cdb_cr0_xer;
  logic            [0:1]         cdb_grant_idx;

  cdb_arbiter #(.UNITS(UNITS), .RS_ID_WIDTH(RSW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .unit_valid           (unit_valid),
    .unit_ready           (unit_ready),
    .unit_rs_id           (unit_rs_id),
    .unit_result_reg_addr (unit_result_reg_addr),
    .unit_result          (unit_result),
    .unit_cr0_xer         (unit_cr0_xer),
    .cdb_valid            (cdb_valid),
    .cdb_ready            (cdb_ready),
    .cdb_rs_id            (cdb_rs_id),
    .cdb_result_reg_addr  (cdb_result_reg_addr),
    .cdb_result           (cdb_result),
    .cdb_cr0_xer          (cdb_cr0_xer),
    .cdb_grant_idx        (cdb_grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic             r;
    logic [0:UNITS-1] v;
    logic             rdy;
    logic [0:UNITS-1] exp_ready;
    logic             exp_cv;
    int               exp_idx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [0:UNITS-1] v, logic rdy,
                              logic [0:UNITS-1] er, logic ecv, int ei);
    vec_t t;
    t.r = r; t.v = v; t.rdy = rdy; t.exp_ready = er; t.exp_cv = ecv; t.exp_idx = ei;
    return t;
  endfunction

  // reference model state
  logic             m_v;
  logic [0:RSW-1]   m_rs;
  logic [0:4]       m_ra;
  logic [0:31]      m_res;
  cond_exception_t  m_cx;
  int               m_ptr;
  logic [0:UNITS-1] pend;
  int               wait_cnt[UNITS];

  task automatic check_model_outputs();
    chk("rnd_cdb_valid", 64'(cdb_valid), 64'(m_v));
    chk("rnd_rs_id", 64'(cdb_rs_id), 64'(m_rs));
    chk("rnd_reg_addr", 64'(cdb_result_reg_addr), 64'(m_ra));
    chk("rnd_result", 64'(cdb_result), 64'(m_res));
    chk("rnd_cr0_xer", 64'(cdb_cr0_xer), 64'(m_cx));
  endtask

  initial begin
    rst = 1'b1;
    unit_valid = '0;
    cdb_ready = 1'b0;
    for (int u = 0; u < UNITS; u++) begin
      unit_rs_id[u]           = RSW'(u);
      unit_result_reg_addr[u] = 5'(u + 8);
      unit_result[u]          = 32'h1000_0000 + 32'(u);
      unit_cr0_xer[u]         = cond_exception_t'(7'(7'h11 * (u + 1)));
    end
    unit_result[3] = 32'h1234_5678;

    // reset
    tbl.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 0));
    // single result from unit 3, one cycle latency, then drain
    tbl.push_back(mk(0, 4'b0001, 1, 4'b0001, 1, 3));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 3));
    // all valid: back-to-back round robin
    tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 1, 1));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 1, 2));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 3));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 1, 0));
    // backpressure for 5 cycles with units 1 and 2 waiting
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 4'b0110, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 4'b0110, 1, 4'b0100, 1, 1));
    // pointer at 2, units 0 and 3 valid
    tbl.push_back(mk(0, 4'b1001, 1, 4'b0001, 1, 3));
    tbl.push_back(mk(0, 4'b1000, 1, 4'b1000, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 1, 1));
    // reset mid-operation, then restart at unit 0
    tbl.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].r;
      unit_valid = tbl[i].v;
      cdb_ready = tbl[i].rdy;
      #1;
      chk($sformatf("t%0d_unit_ready", i), 64'(unit_ready), 64'(tbl[i].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_cdb_valid", i), 64'(cdb_valid), 64'(tbl[i].exp_cv));
      if (tbl[i].r) begin
        chk($sformatf("t%0d_rst_data", i),
            {cdb_rs_id, cdb_result_reg_addr, cdb_result, cdb_cr0_xer, cdb_grant_idx}, 64'd0);
      end else if (tbl[i].exp_cv) begin
        chk($sformatf("t%0d_grant_idx", i), 64'(cdb_grant_idx), 64'(tbl[i].exp_idx));
        chk($sformatf("t%0d_rs_id", i), 64'(cdb_rs_id), 64'(unit_rs_id[tbl[i].exp_idx]));
        chk($sformatf("t%0d_result", i), 64'(cdb_result), 64'(unit_result[tbl[i].exp_idx]));
        chk($sformatf("t%0d_reg_addr", i), 64'(cdb_result_reg_addr),
            64'(unit_result_reg_addr[tbl[i].exp_idx]));
        chk($sformatf("t%0d_cr0_xer", i), 64'(cdb_cr0_xer), 64'(unit_cr0_xer[tbl[i].exp_idx]));
      end
    end

    // randomized phase against the reference model; starts with a reset
    pend = '0;
    m_v = 0; m_rs = '0; m_ra = '0; m_res = '0; m_cx = '0; m_ptr = 0;
    for (int u = 0; u < UNITS; u++) wait_cnt[u] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic r;
      int g;
      logic [0:UNITS-1] exp_ready;
      @(negedge clk);
      for (int u = 0; u < UNITS; u++) begin
        if (!pend[u] && $urandom_range(1, 0) == 1) begin
          pend[u] = 1'b1;
          unit_rs_id[u]           = RSW'($urandom);
          unit_result_reg_addr[u] = 5'($urandom);
          unit_result[u]          = $urandom;
          unit_cr0_xer[u]         = cond_exception_t'(7'($urandom));
        end
      end
      r = (cyc == 0) || ($urandom_range(49, 0) == 0);
      rst = r;
      cdb_ready = ($urandom_range(3, 0) != 0);
      unit_valid = pend;
      #1;
      g = -1;
      if (!r && (!m_v || cdb_ready)) begin
        for (int k = 0; k < UNITS; k++) begin
          int idx;
          idx = (m_ptr + k) % UNITS;
          if (g < 0 && pend[idx]) g = idx;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("rnd_unit_ready", 64'(unit_ready), 64'(exp_ready));
      @(posedge clk);
      if (r) begin
        m_v = 0; m_rs = '0; m_ra = '0; m_res = '0; m_cx = '0; m_ptr = 0;
        for (int u = 0; u < UNITS; u++) wait_cnt[u] = 0;
      end else if (g >= 0) begin
        n_vec++;
        if (wait_cnt[g] > UNITS - 1) begin
          n_err++;
          $display("FAIL rnd_fairness: unit %0d waited %0d transfers, limit %0d",
                   g, wait_cnt[g], UNITS - 1);
        end
        for (int u = 0; u < UNITS; u++) if (pend[u] && u != g) wait_cnt[u]++;
        wait_cnt[g] = 0;
        m_v = 1; m_rs = unit_rs_id[g]; m_ra = unit_result_reg_addr[g];
        m_res = unit_result[g]; m_cx = unit_cr0_xer[g];
        m_ptr = (g + 1) % UNITS;
        pend[g] = 1'b0;
      end else if (cdb_ready) begin
        m_v = 0;
      end
      #1;
      check_model_outputs();
      if (g >= 0) chk("rnd_grant_idx", 64'(cdb_grant_idx), 64'(g));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
